// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit between EXU and WBU: one valid/ready bus access per instruction.
// Optional misalignment check for lw/sw: define YSYX_25020047_LSU_ALIGN_CHK_EN.
module ysyx_25020047_lsu #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  inst_type,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] memdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_M1 =
    TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  state_t           r_state;
  logic             r_lw;
  logic             r_lbu;
  logic [1:0]       r_off;
  logic [CNT_W-1:0] r_cnt;

  logic        w_lw;
  logic        w_lbu;
  logic        w_sw;
  logic        w_sb;
  logic        w_mem;
  logic        w_mis;
  logic [31:0] w_load;

  assign w_lw  = (inst_type == 9'b0_0010_0000);
  assign w_lbu = (inst_type == 9'b0_0100_0000);
  assign w_sw  = (inst_type == 9'b0_1000_0000);
  assign w_sb  = (inst_type == 9'b1_0000_0000);
  assign w_mem = w_lw | w_lbu | w_sw | w_sb;

`ifdef YSYX_25020047_LSU_ALIGN_CHK_EN
  assign w_mis = (w_lw | w_sw) & (addr[1:0] != 2'b00);
`else
  assign w_mis = 1'b0;
`endif

  // Stores return zero; only the latched load kind selects data.
  always_comb begin
    w_load = 32'h0;
    if (r_lw)
      w_load = mem_resp_rdata;
    else if (r_lbu)
      w_load = {24'h0, mem_resp_rdata[{r_off, 3'b000} +: 8]};
  end

  assign in_ready = (r_state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_lw          <= 1'b0;
      r_lbu         <= 1'b0;
      r_off         <= 2'b00;
      r_cnt         <= '0;
      out_valid     <= 1'b0;
      memdata       <= 32'h0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= 32'h0;
      mem_req_wen   <= 1'b0;
      mem_req_wdata <= 32'h0;
      mem_req_wmask <= 4'h0;
      err           <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_lw    <= w_lw;
            r_lbu   <= w_lbu;
            r_off   <= addr[1:0];
            memdata <= 32'h0;
            if (w_mis) begin
              err       <= 1'b1;
              out_valid <= 1'b1;
              r_state   <= DONE;
            end else if (w_mem) begin
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {addr[31:2], 2'b00};
              mem_req_wen   <= w_sw | w_sb;
              mem_req_wdata <= w_sb ? {4{st_data[7:0]}}
                                    : st_data;
              mem_req_wmask <= w_sw ? 4'b1111
                             : w_sb ? 4'b0001 << addr[1:0]
                                    : 4'b0000;
              r_state       <= REQ;
            end else begin
              out_valid <= 1'b1;
              r_state   <= DONE;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            r_cnt         <= '0;
            r_state       <= WAIT;
          end
        end
        WAIT: begin
          // A response arriving on the timeout cycle still wins.
          if (mem_resp_valid) begin
            memdata   <= w_load;
            out_valid <= 1'b1;
            r_state   <= DONE;
          end else if (TO_EN && r_cnt == TO_M1) begin
            memdata   <= 32'h0;
            err       <= 1'b1;
            out_valid <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Randomized self-checking bench for ysyx_25020047_lsu (TIMEOUT=4).
// Model tracks expected data, bus fields, latency and sticky err.
module tb_ysyx_25020047_lsu;

  localparam int TO = 4;
  localparam logic [8:0] T_LW  = 9'h020;
  localparam logic [8:0] T_LBU = 9'h040;
  localparam logic [8:0] T_SW  = 9'h080;
  localparam logic [8:0] T_SB  = 9'h100;
`ifdef YSYX_25020047_LSU_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  inst_type;
  logic [31:0] addr;
  logic [31:0] st_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] memdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        err;

  int vectors = 0;
  int miscompares = 0;
  logic exp_err = 1'b0;

  always #5 clk = ~clk;

  ysyx_25020047_lsu #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .inst_type(inst_type), .addr(addr), .st_data(st_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .memdata(memdata),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata),
    .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata),
    .err(err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // 1 lw, 2 lbu, 3 sw, 4 sb, 0 anything else
  function automatic int kind(input logic [8:0] t);
    if (t == T_LW)  return 1;
    if (t == T_LBU) return 2;
    if (t == T_SW)  return 3;
    if (t == T_SB)  return 4;
    return 0;
  endfunction

  // One complete instruction with the bench acting as bus and WBU.
  task automatic do_op(input logic [8:0] t, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rd,
                       input int reqd, input int respd,
                       input int outd, input string nm);
    int k;
    bit mis;
    bit mem;
    bit tout;
    int nidle;
    logic [31:0] e_md;
    logic [31:0] e_wd;
    logic [31:0] e_ad;
    logic [3:0]  e_wm;
    k    = kind(t);
    mis  = ALIGN && (k == 1 || k == 3) && (a % 4 != 0);
    mem  = (k != 0) && !mis;
    tout = mem && (k <= 2 || k >= 3) && respd >= TO;
    e_ad = a - (a % 4);
    e_md = 32'h0;
    if (!tout && !mis && k == 1) e_md = rd;
    if (!tout && k == 2) e_md = (rd >> (8 * (a % 4))) & 32'hff;
    e_wm = (k == 3) ? 4'hf : (k == 4) ? 4'(1 << (a % 4)) : 4'h0;
    e_wd = (k == 4) ? {24'h0, sd[7:0]} * 32'h01010101 : sd;

    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s in_ready(idle) got %b want 1", nm, in_ready);
    end
    in_valid  = 1'b1;
    inst_type = t;
    addr      = a;
    st_data   = sd;
    tick();
    in_valid  = 1'b0;
    inst_type = 9'($urandom);
    addr      = $urandom;
    st_data   = $urandom;

    if (mem) begin
      for (int i = 0; i <= reqd; i++) begin
        vectors++;
        if (mem_req_valid !== 1'b1 || out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL %s req_valid/out_valid got %b/%b want 1/0",
                   nm, mem_req_valid, out_valid);
        end
        vectors++;
        if (mem_req_addr !== e_ad) begin
          miscompares++;
          $display("FAIL %s req_addr got %h want %h", nm, mem_req_addr, e_ad);
        end
        vectors++;
        if (mem_req_wen !== (k >= 3)) begin
          miscompares++;
          $display("FAIL %s req_wen got %b want %b", nm, mem_req_wen, k >= 3);
        end
        if (k >= 3) begin
          vectors++;
          if (mem_req_wmask !== e_wm || mem_req_wdata !== e_wd) begin
            miscompares++;
            $display("FAIL %s wmask/wdata got %b/%h want %b/%h", nm,
                     mem_req_wmask, mem_req_wdata, e_wm, e_wd);
          end
        end
        mem_req_ready = (i == reqd);
        tick();
      end
      mem_req_ready = 1'b0;
      vectors++;
      if (mem_req_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL %s req_valid(after hs) got %b want 0", nm, mem_req_valid);
      end
      nidle = tout ? TO : respd;
      for (int i = 0; i < nidle; i++) begin
        vectors++;
        if (out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL %s out_valid(wait %0d) got %b want 0", nm, i, out_valid);
        end
        tick();
      end
      if (!tout) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rd;
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_rdata = $urandom;
      end
      if (tout) exp_err = 1'b1;
    end else begin
      if (mis) exp_err = 1'b1;
      vectors++;
      if (mem_req_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL %s req_valid(no bus) got %b want 0", nm, mem_req_valid);
      end
    end

    for (int i = 0; i <= outd; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL %s out_valid/in_ready(done) got %b/%b want 1/0",
                 nm, out_valid, in_ready);
      end
      vectors++;
      if (memdata !== e_md) begin
        miscompares++;
        $display("FAIL %s memdata got %h want %h", nm, memdata, e_md);
      end
      vectors++;
      if (err !== exp_err) begin
        miscompares++;
        $display("FAIL %s err got %b want %b", nm, err, exp_err);
      end
      out_ready = (i == outd);
      tick();
    end
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s out_valid/in_ready(after) got %b/%b want 0/1",
               nm, out_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    in_valid  = 1'b1;
    inst_type = T_LW;
    addr      = $urandom;
    tick();
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    exp_err  = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset in_ready/out_valid/err got %b/%b/%b want 1/0/0",
               in_ready, out_valid, err);
    end
    vectors++;
    if (memdata !== 32'h0 || mem_req_valid !== 1'b0 ||
        mem_req_wen !== 1'b0 || mem_req_wmask !== 4'h0) begin
      miscompares++;
      $display("FAIL reset memdata/rv/wen/wmask got %h/%b/%b/%b want 0",
               memdata, mem_req_valid, mem_req_wen, mem_req_wmask);
    end
    vectors++;
    if (mem_req_addr !== 32'h0 || mem_req_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset addr/wdata got %h/%h want 0/0",
               mem_req_addr, mem_req_wdata);
    end
  endtask

  task automatic test_directed;
    do_op(T_LW,  32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, "lw");
    do_op(T_LBU, 32'h8000_0007, 32'h0, 32'h1234_5678, 0, 0, 0, "lbu7");
    do_op(T_LBU, 32'h8000_0005, 32'h0, 32'h1234_5678, 0, 1, 0, "lbu5");
    do_op(T_SB,  32'h8000_0002, 32'hAB, 32'h5555_5555, 0, 0, 0, "sb");
    do_op(T_SW,  32'h8000_0010, 32'hCAFE_F00D, 32'h0, 1, 0, 0, "sw");
    do_op(T_LW,  32'h8000_0001, 32'h0, 32'h0BAD_F00D, 0, 0, 0, "lw_mis");
    do_op(9'h000, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0, "nonmem");
    do_op(T_LW | T_SB, 32'h8000_0000, 32'h1, 32'h0, 0, 0, 0, "multi");
  endtask

  task automatic test_backpressure;
    do_op(T_LW, 32'h8000_0020, 32'h0, 32'h0123_4567, 5, 0, 3, "bp");
    do_op(T_SB, 32'h8000_0023, 32'h5A, 32'h0, 5, 2, 3, "bp_sb");
  endtask

  task automatic test_boundary;
    do_op(T_LBU, 32'h8000_0006, 32'h0, 32'hA1B2_C3D4, 0, TO - 1, 0, "resp_wins");
  endtask

  task automatic test_random;
    logic [8:0] t;
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 6))
        0: t = T_LW;
        1: t = T_LBU;
        2: t = T_SW;
        3: t = T_SB;
        4: t = 9'h000;
        5: t = 9'(1 << $urandom_range(0, 4));
        default: t = T_LBU | T_SW;
      endcase
      do_op(t, $urandom, $urandom, $urandom, $urandom_range(0, 3),
            $urandom_range(0, TO - 1), $urandom_range(0, 2), "rand");
    end
  endtask

  task automatic test_timeout;
    do_op(T_LW, 32'h8000_0040, 32'h0, 32'hFFFF_FFFF, 0, TO, 1, "timeout");
    do_op(T_LW, 32'h8000_0044, 32'h0, 32'h1111_2222, 0, 0, 0, "sticky");
    test_reset();
  endtask

  task automatic test_reset_mid;
    in_valid  = 1'b1;
    inst_type = T_LW;
    addr      = 32'h8000_0080;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || mem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid in_ready/req/out got %b/%b/%b want 1/0/0",
               in_ready, mem_req_valid, out_valid);
    end
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h7777_7777;
    tick();
    mem_resp_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || memdata !== 32'h0) begin
      miscompares++;
      $display("FAIL late_resp out_valid/in_ready/memdata got %b/%b/%h want 0/1/0",
               out_valid, in_ready, memdata);
    end
    do_op(T_LW, 32'h8000_0084, 32'h0, 32'h2468_ACE0, 0, 0, 0, "post_rst");
  endtask

  initial begin
    rst            = 1'b1;
    in_valid       = 1'b0;
    inst_type      = 9'h0;
    addr           = 32'h0;
    st_data        = 32'h0;
    out_ready      = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 32'h0;
    test_reset();
    test_directed();
    test_backpressure();
    test_boundary();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ysyx_25020047_lsu.md
Name: ysyx_25020047_lsu

Overview:
- Load/store unit between EXU and WBU.
- Takes the one-hot inst_type and the EXU result (used as the effective address), runs one access on a valid/ready memory bus, and returns load data aligned and zero-extended.
- WBU consumes memdata unchanged for lw/lbu.
- Non-memory instructions pass through with memdata=0.

Parameters:
- TIMEOUT, 255: max cycles waiting in WAIT for mem_resp_valid before aborting; 0 disables timeout.
- CNT_W, 8: width of the timeout counter; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  EXU presents an instruction
- in_ready  out  1  LSU accepts; high only in IDLE
- inst_type  in  9  one-hot: bit5 lw, bit6 lbu, bit7 sw, bit8 sb; any other value is non-memory
- addr  in  32  effective address (EXU result)
- st_data  in  32  store data (rs2)
- out_valid  out  1  result available to WBU
- out_ready  in  1  WBU accepts
- memdata  out  32  load result; 0 for stores and non-memory instructions
- mem_req_valid  out  1  bus request
- mem_req_ready  in  1  bus accepts request
- mem_req_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- mem_req_wen  out  1  1 = store
- mem_req_wdata  out  32  store data, lane-replicated
- mem_req_wmask  out  4  byte enables
- mem_resp_valid  in  1  bus response / write ack
- mem_resp_rdata  in  32  read word
- err  out  1  sticky error flag (timeout; misalignment when feature enabled)

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE. in_ready=1. out_valid=0, memdata=0, mem_req_valid=0, mem_req_wen=0, mem_req_wmask=0, mem_req_addr=0, mem_req_wdata=0, err=0, timeout counter=0. Reset mid-transaction abandons it; any late mem_resp_valid is ignored in IDLE.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On in_valid&in_ready, latch inst_type, addr, st_data.
  - Memory op -> REQ next cycle.
  - Non-memory op -> DONE with memdata=0 (1-cycle pass-through latency).
- REQ:
  - mem_req_valid=1; addr/wen/wdata/wmask held stable until mem_req_ready.
  - On mem_req_ready -> WAIT, counter cleared.
- WAIT:
  - On mem_resp_valid, capture the load result -> DONE.
  - Each cycle without a response, counter+1. If TIMEOUT!=0 and counter reaches TIMEOUT -> DONE with memdata=0 and err set.
  - mem_resp_valid in the same cycle the counter hits TIMEOUT: the response wins, no error.
- DONE:
  - out_valid=1, memdata held.
  - On out_ready -> IDLE. in_ready rises the following cycle; there is no back-to-back acceptance in the DONE cycle.
- Load data:
  - lw: memdata = rdata.
  - lbu: memdata = {24'b0, rdata byte selected by addr[1:0]} (00 -> [7:0] ... 11 -> [31:24]).
- Store encoding:
  - sw: wmask=4'b1111, wdata=st_data.
  - sb: wmask=4'b0001<<addr[1:0], wdata={4{st_data[7:0]}}.
  - memdata=0 after the write ack.
- Minimum latency for a memory op with zero-wait bus: accept (cycle 0), REQ (1), WAIT with response (2), out_valid (3).
- err is sticky until rst.
- Multiple bits set in inst_type are treated as non-memory.

Optional Feature:
- Macro: YSYX_25020047_LSU_ALIGN_CHK_EN.
- Defined:
  - lw/sw with addr[1:0]!=0 skips REQ/WAIT and goes IDLE -> DONE directly.
  - memdata=0, no bus request issued, err set.
- Undefined:
  - addr[1:0] is ignored for lw/sw; the aligned word is accessed, no error.
  - err is set by timeout only.

Test Plan:
- lw, addr=0x80000004, bus ready immediately, rdata=0xDEADBEEF one cycle later -> mem_req_addr=0x80000004, out_valid 3 cycles after accept, memdata=0xDEADBEEF, err=0.
- lbu, addr=0x80000007, rdata=0x12345678 -> memdata=0x00000012. Repeat with addr=...05 -> 0x00000056.
- sb, addr=0x80000002, st_data=0x000000AB -> wen=1, wmask=4'b0100, wdata=0xABABABAB; after ack, memdata=0.
- Backpressure:
  - mem_req_ready low 5 cycles -> request fields held stable.
  - out_ready low 3 cycles in DONE -> out_valid and memdata held, in_ready=0.
- TIMEOUT=4, no mem_resp_valid -> DONE after 4 WAIT cycles, memdata=0, err=1 until rst; then rst pulse -> all outputs at reset values, in_ready=1.
- With YSYX_25020047_LSU_ALIGN_CHK_EN, lw addr=0x80000001 -> no mem_req_valid, err=1, memdata=0. Without the macro -> mem_req_addr=0x80000000, normal completion.
